// File: rtl/madd_sweep_pkg.sv
// Shared definitions for the approximate multiply-add error sweep.
// Holds operand/result widths, the sweep FSM state type, the number of
// vectors in an exhaustive sweep and the exact a*b+c reference function.
package madd_sweep_pkg;

    localparam int unsigned OP_W  = 2;            // a, b, c operand width
    localparam int unsigned RES_W = 4;            // netlist result width
    localparam int unsigned VEC_W = 3 * OP_W;     // packed input vector width
    localparam int unsigned N_VEC = 1 << VEC_W;   // 64 vectors per sweep

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // Exact model: a = v[1:0], b = v[3:2], c = v[5:4]; result 0..12.
    function automatic logic [RES_W-1:0] madd_exact(input logic [VEC_W-1:0] v);
        logic [RES_W-1:0] a;
        logic [RES_W-1:0] b;
        logic [RES_W-1:0] c;
        a = {2'b00, v[1:0]};
        b = {2'b00, v[3:2]};
        c = {2'b00, v[5:4]};
        return a * b + c;
    endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Combinational exact reference for the 6-input/4-output multiply-add.
// Ports:
//   vec_i   [5:0]  packed operands {c, b, a}
//   exact_o [3:0]  a*b + c
module madd_exact_ref
    import madd_sweep_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic [RES_W-1:0] exact_o
);

    assign exact_o = madd_exact(vec_i);

endmodule

// File: rtl/madd_err_sweep_ctrl.sv
// Exhaustive in-system error characterisation of an approximate a*b+c
// netlist. Walks all 64 input vectors, compares each response with the
// exact model and accumulates worst-case, count and sum of |error|.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    host control (start honoured only in IDLE)
//   vec_o    [5:0]  vector driven into the approximate netlist
//   approx_i [3:0]  netlist response, sampled in CHECK only
//   busy, done      sweep in progress / one-cycle completion pulse
//   pass            max_err <= ET, valid from done until next start
//   max_err, worst_vec, err_count, err_sum   accumulated statistics
module madd_err_sweep_ctrl
    import madd_sweep_pkg::*;
#(
    parameter logic [3:0]  ET      = 4'd2,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec_o,
    input  logic [RES_W-1:0] approx_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       max_err,
    output logic [VEC_W-1:0] worst_vec,
    output logic [6:0]       err_count,
    output logic [9:0]       err_sum
);

    // Last value of the wait counter; unused when DUT_LAT is 0.
    localparam logic [2:0] LAT_LAST = 3'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       max_q, max_d;
    logic [VEC_W-1:0] worst_q, worst_d;
    logic [6:0]       ecnt_q, ecnt_d;
    logic [9:0]       sum_q, sum_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [RES_W-1:0] exact;
    logic [3:0]       err;

    madd_exact_ref u_ref (
        .vec_i   (vec_q),
        .exact_o (exact)
    );

    // Absolute difference; the magnitude always fits in 4 bits.
    assign err = (approx_i >= exact) ? (approx_i - exact) : (exact - approx_i);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        worst_d = worst_q;
        ecnt_d  = ecnt_q;
        sum_d   = sum_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    max_d   = '0;
                    worst_d = '0;
                    ecnt_d  = '0;
                    sum_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (DUT_LAT > 0) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = CHECK;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == LAT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (err != '0) ecnt_d = ecnt_q + 7'd1;
                    sum_d = sum_q + 10'(err);
                    if (err > max_q) begin
                        max_d   = err;
                        worst_d = vec_q;
                    end
                    if (vec_q == VEC_W'(N_VEC - 1)) begin
                        state_d = DONE;
                        // Use the updated maximum so the last vector counts.
                        pass_d  = (max_d <= ET);
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            worst_q <= '0;
            ecnt_q  <= '0;
            sum_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            worst_q <= worst_d;
            ecnt_q  <= ecnt_d;
            sum_q   <= sum_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec_o     = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign max_err   = max_q;
    assign worst_vec = worst_q;
    assign err_count = ecnt_q;
    assign err_sum   = sum_q;

endmodule

// File: doc/madd_err_sweep_ctrl.md
# madd_err_sweep_ctrl

Sequencer that exhaustively characterises one approximate 6-input/4-output multiply-add netlist (a*b+c, 2-bit operands) in-system. It walks all 64 input vectors into the combinational approximate circuit, compares each response against an internal exact model, and accumulates worst-case, count and sum of absolute error. A final pass/fail is reported against the error threshold the netlist was synthesised for. It sits between a host/test controller (start/done handshake) and the approximate datapath instance.

## Interface
- `ET`, 2: error threshold; pass when max absolute error <= ET (4-bit unsigned).
- `DUT_LAT`, 0: cycles between `vec_o` update and `approx_i` being valid (0..7).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  stop the current sweep; return to IDLE, no done.
- `vec_o`  out  6  vector to the netlist; bit i drives `in<i>`.
- `approx_i`  in  4  netlist response; bit i from `out<i>`.
- `busy`  out  1  high from DRIVE through CHECK of the last vector.
- `done`  out  1  one-cycle pulse, sweep complete.
- `pass`  out  1  `max_err <= ET`; valid when done pulses, held until next start.
- `max_err`  out  4  largest |approx - exact|.
- `worst_vec`  out  6  lowest-index vector that produced `max_err`.
- `err_count`  out  7  number of vectors with nonzero error (0..64).
- `err_sum`  out  10  sum of |approx - exact| (max 64*15 = 960).

## Operation
- Exact model: a = vec[1:0], b = vec[3:2], c = vec[5:4]; exact = a*b + c, 4-bit, range 0..12.
- Error: 4-bit unsigned |approx_i - exact|, computed at 5 bits then truncated; cannot overflow.
- FSM states:
  - IDLE: `start` -> DRIVE. Clear all results and `pass`, set `vec_o` = 0.
  - DRIVE: one cycle; `vec_o` is stable. -> WAIT if DUT_LAT > 0, else CHECK.
  - WAIT: counts DUT_LAT cycles, then -> CHECK.
  - CHECK: sample `approx_i`.
    - If err != 0: increment `err_count`.
    - Add err to `err_sum`.
    - If err > `max_err` (strictly greater): update `max_err` and `worst_vec`.
    - If `vec_o` == 63 -> DONE; else increment `vec_o` and -> DRIVE.
  - DONE: `done` = 1 and `pass` registered, one cycle; -> IDLE.
- `abort` is checked in DRIVE, WAIT and CHECK and has priority over CHECK accumulation. On abort, go to IDLE; accumulators freeze at their partial values; `pass` = 0; no `done`.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: start wins.
- `vec_o` does not wrap; the sweep ends at 63.

## Timing
- Reset values: `vec_o` 0, `busy` 0, `done` 0, `pass` 0, `max_err` 0, `worst_vec` 0, `err_count` 0, `err_sum` 0; state IDLE.
- Reset mid-sweep clears everything immediately (async); there is no resume.
- `start` is sampled at edge E. `busy` = 1 and vector 0 is in DRIVE from E+1.
- Each vector takes DUT_LAT+2 cycles.
- `done` is high in cycle E + 64*(DUT_LAT+2) + 1. `busy` falls in that same cycle.
- All outputs are registered. `approx_i` is the only combinational input used, and only in CHECK.

## Structure
- Package `madd_sweep_pkg` holds:
  - operand/result widths (2/4);
  - state enum (IDLE, DRIVE, WAIT, CHECK, DONE);
  - vector count 64;
  - the `madd_exact` function.
- Sub-module `madd_exact_ref` (combinational, 6 in -> 4 out, wraps `madd_exact`). It is reused by the bench scoreboard.
- Top level holds the FSM, the latency counter and the accumulators.

## Test plan
- `approx_i` looped to the exact model, DUT_LAT=0 -> `err_count` 0, `max_err` 0, `err_sum` 0, `pass` 1, `done` at E+129.
- `approx_i` tied to 0 -> `max_err` 12, `worst_vec` 63, `err_count` 57, `err_sum` 240, `pass` 0.
- `approx_i` = exact ^ 1, ET=2 -> `err_count` 64, `max_err` 1, `worst_vec` 0, `err_sum` 64, `pass` 1. Same stimulus with ET=0 -> `pass` 0.
- DUT_LAT=3 with a one-cycle-late model: loopback through a 3-stage delay -> zero error, `done` at E+321.
- `abort` while `vec_o`=10; `start` pulses during the sweep -> extra starts ignored; after abort, no `done`, `busy` 0 next cycle, `pass` 0, `vec_o` frozen at 10.
- `rst` asserted mid-sweep, between edges -> all outputs 0 immediately. A following `start` gives a full clean sweep with results identical to an uninterrupted run.
